alu_issue_unit: RTL

- Initiator for the single-cycle 32-bit ALU: it drives `ALUOperation`/`A`/`B` and samples `ALUResult`/`Zero`.
- Accepts decoded-field requests from the datapath over a valid/ready handshake. It maps MIPS opcode/funct to the ALU's 4-bit operation code and forms operands: immediate extension, shift amount, LUI.
- Registers the ALU inputs, captures the result one cycle later, and returns it on a valid/ready response channel.
- Sits between the decode stage and the ALU in the multi-cycle datapath.

---
 rtl/alu_issue_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: decodes MIPS opcode/funct into ALU controls, issues them,
// captures the result one cycle later and returns it on a response channel.
// Ports: clk, reset (async active-low); req_* valid/ready request with
// decoded instruction fields; alu_* drive/sample the single-cycle ALU;
// resp_* valid/ready response with result, zero flag and illegal flag.
// Optional macro ALU_ISSUE_PIPE_EN: overlap response handshake with the
// next request accept (RESP->EXEC directly).
module alu_issue_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [5:0]            req_opcode,
    input  logic [5:0]            req_funct,
    input  logic [4:0]            req_shamt,
    input  logic [DATA_WIDTH-1:0] req_rs_data,
    input  logic [DATA_WIDTH-1:0] req_rt_data,
    input  logic [15:0]           req_imm,
    output logic [3:0]            alu_operation,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic                  resp_zero,
    output logic                  resp_illegal
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_NOR = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_LUI = 4'd8;

    state_t state;
    logic   ill_q;

    logic [3:0]            dec_op;
    logic [DATA_WIDTH-1:0] dec_a;
    logic [DATA_WIDTH-1:0] dec_b;
    logic                  dec_ill;

    logic                  is_r;
    logic [DATA_WIDTH-1:0] imm_sx;
    logic [DATA_WIDTH-1:0] imm_zx;
    logic [DATA_WIDTH-1:0] sh_zx;

    assign is_r   = (req_opcode == 6'h00);
    assign imm_sx = {{(DATA_WIDTH-16){req_imm[15]}}, req_imm};
    assign imm_zx = {{(DATA_WIDTH-16){1'b0}}, req_imm};
    assign sh_zx  = {{(DATA_WIDTH-5){1'b0}}, req_shamt};

    always_comb begin
        dec_op  = OP_AND;
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b0;
        unique case (1'b1)
            is_r && (req_funct == 6'h24): begin
                dec_op = OP_AND;
                dec_a  = req_rs_data;
                dec_b  = req_rt_data;
            end
            is_r && (req_funct == 6'h25): begin
                dec_op = OP_OR;
                dec_a  = req_rs_data;
                dec_b  = req_rt_data;
            end
            is_r && (req_funct == 6'h27): begin
                dec_op = OP_NOR;
                dec_a  = req_rs_data;
                dec_b  = req_rt_data;
            end
            is_r && (req_funct == 6'h20): begin
                dec_op = OP_ADD;
                dec_a  = req_rs_data;
                dec_b  = req_rt_data;
            end
            is_r && (req_funct == 6'h00): begin
                dec_op = OP_SLL;
                dec_a  = req_rt_data;
                dec_b  = sh_zx;
            end
            is_r && (req_funct == 6'h02): begin
                dec_op = OP_SRL;
                dec_a  = req_rt_data;
                dec_b  = sh_zx;
            end
            req_opcode == 6'h08: begin
                dec_op = OP_ADD;
                dec_a  = req_rs_data;
                dec_b  = imm_sx;
            end
            req_opcode == 6'h0D: begin
                dec_op = OP_OR;
                dec_a  = req_rs_data;
                dec_b  = imm_zx;
            end
            req_opcode == 6'h0C: begin
                dec_op = OP_AND;
                dec_a  = req_rs_data;
                dec_b  = imm_zx;
            end
            req_opcode == 6'h0F: begin
                dec_op = OP_LUI;
                dec_b  = imm_zx;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

`ifdef ALU_ISSUE_PIPE_EN
    assign req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
`else
    assign req_ready = (state == IDLE);
`endif
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            alu_operation <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            ill_q         <= 1'b0;
            resp_result   <= '0;
            resp_zero     <= 1'b0;
            resp_illegal  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_operation <= dec_op;
                        alu_a         <= dec_a;
                        alu_b         <= dec_b;
                        ill_q         <= dec_ill;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result  <= alu_result;
                    resp_zero    <= alu_zero;
                    resp_illegal <= ill_q;
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
`ifdef ALU_ISSUE_PIPE_EN
                        if (req_valid) begin
                            alu_operation <= dec_op;
                            alu_a         <= dec_a;
                            alu_b         <= dec_b;
                            ill_q         <= dec_ill;
                            state         <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
